// File: rtl/spi_flash_id_reader.sv
// SPI mode-0 master that issues JEDEC Read-ID (0x9F) and captures the 3-byte flash ID.
// Define FLASH_WAKEUP_EN to precede every read with Release-Power-Down (0xAB) plus a CS-high gap.
`timescale 1ns/1ps
module spi_flash_id_reader #(
    parameter int CLK_DIV     = 4,
    parameter int WAKE_CYCLES = 240
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [23:0] id,
    output logic        id_valid,
    output logic        sck,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);

    localparam int             TW        = $clog2(CLK_DIV + 1);
    localparam logic [TW-1:0]  T_RELOAD  = TW'(CLK_DIV - 1);
    localparam logic [7:0]     CMD_RDID  = 8'h9F;

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("CLK_DIV must be in 1..255");
    end
    if (WAKE_CYCLES < 1) begin : g_bad_wake_cycles
        $error("WAKE_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
`ifdef FLASH_WAKEUP_EN
        WAKE_SETUP,
        WAKE_SHIFT,
        WAKE_HOLD,
        WAKE_GAP,
`endif
        CS_SETUP,
        SHIFT,
        CS_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [5:0]      bit_q, bit_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [23:0]     sh_q, sh_d;
    logic            sck_d, cs_n_d, busy_d, done_d, id_valid_d;
    logic [23:0]     id_d;
    logic            tmr_zero;

`ifdef FLASH_WAKEUP_EN
    localparam int             GW        = $clog2(WAKE_CYCLES + 1);
    localparam logic [GW-1:0]  G_RELOAD  = GW'(WAKE_CYCLES - 1);
    localparam logic [7:0]     CMD_RPD   = 8'hAB;
    logic [GW-1:0]   gap_q, gap_d;
    logic            gap_zero;
    assign gap_zero = (gap_q == '0);
`endif

    assign tmr_zero = (tmr_q == '0);
    // The command register doubles as the MOSI flop; it drains to zero for the read bits.
    assign mosi = cmd_q[7];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            bit_q    <= '0;
            cmd_q    <= '0;
            sh_q     <= '0;
            sck      <= 1'b0;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            id       <= '0;
            id_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            bit_q    <= bit_d;
            cmd_q    <= cmd_d;
            sh_q     <= sh_d;
            sck      <= sck_d;
            cs_n     <= cs_n_d;
            busy     <= busy_d;
            done     <= done_d;
            id       <= id_d;
            id_valid <= id_valid_d;
        end
    end

`ifdef FLASH_WAKEUP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) gap_q <= '0;
        else          gap_q <= gap_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_zero ? tmr_q : tmr_q - 1'b1;
        bit_d      = bit_q;
        cmd_d      = cmd_q;
        sh_d       = sh_q;
        sck_d      = sck;
        cs_n_d     = cs_n;
        busy_d     = busy;
        done_d     = 1'b0;
        id_d       = id;
        id_valid_d = id_valid;
`ifdef FLASH_WAKEUP_EN
        gap_d      = gap_zero ? gap_q : gap_q - 1'b1;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef FLASH_WAKEUP_EN
                    state_d = WAKE_SETUP;
                    cmd_d   = CMD_RPD;
`else
                    state_d = CS_SETUP;
                    cmd_d   = CMD_RDID;
`endif
                    tmr_d      = T_RELOAD;
                    bit_d      = '0;
                    cs_n_d     = 1'b0;
                    sck_d      = 1'b0;
                    busy_d     = 1'b1;
                    id_valid_d = 1'b0;
                end
            end

`ifdef FLASH_WAKEUP_EN
            WAKE_SETUP: begin
                if (tmr_zero) begin
                    state_d = WAKE_SHIFT;
                    tmr_d   = T_RELOAD;
                end
            end

            WAKE_SHIFT: begin
                if (tmr_zero) begin
                    tmr_d = T_RELOAD;
                    if (!sck) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        cmd_d = {cmd_q[6:0], 1'b0};
                        if (bit_q == 6'd7) state_d = WAKE_HOLD;
                        else               bit_d   = bit_q + 6'd1;
                    end
                end
            end

            WAKE_HOLD: begin
                if (tmr_zero) begin
                    cs_n_d  = 1'b1;
                    gap_d   = G_RELOAD;
                    state_d = WAKE_GAP;
                end
            end

            WAKE_GAP: begin
                if (gap_zero) begin
                    state_d = CS_SETUP;
                    tmr_d   = T_RELOAD;
                    bit_d   = '0;
                    cmd_d   = CMD_RDID;
                    cs_n_d  = 1'b0;
                end
            end
`endif

            CS_SETUP: begin
                if (tmr_zero) begin
                    state_d = SHIFT;
                    tmr_d   = T_RELOAD;
                end
            end

            // Each bit is a low half then a high half; miso is captured on the rising step.
            SHIFT: begin
                if (tmr_zero) begin
                    tmr_d = T_RELOAD;
                    if (!sck) begin
                        sck_d = 1'b1;
                        if (bit_q >= 6'd8) sh_d = {sh_q[22:0], miso};
                    end else begin
                        sck_d = 1'b0;
                        cmd_d = {cmd_q[6:0], 1'b0};
                        if (bit_q == 6'd31) state_d = CS_HOLD;
                        else                bit_d   = bit_q + 6'd1;
                    end
                end
            end

            // The done cycle stays here so a start coinciding with done is not seen in IDLE.
            CS_HOLD: begin
                if (done) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (tmr_zero) begin
                    cs_n_d     = 1'b1;
                    done_d     = 1'b1;
                    id_d       = sh_q;
                    id_valid_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
